// File: rtl/perceptron_arbiter.sv
// perceptron_arbiter: round-robin sharing of one perceptron unit between two requesters.
// Ports: clk/rst_n (sync, active-low); reqN_valid/ready/x/weight request handshakes;
// respN_valid/ready/p response handshakes; pe_x/pe_weight registered perceptron drive,
// pe_p perceptron output; busy (not IDLE); grant_id (owner of current/last transaction).
module perceptron_arbiter #(
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [2:1]  req0_x,
   input  logic [2:1]  req1_x,
   input  logic [12:0] req0_weight,
   input  logic [12:0] req1_weight,
   output logic        resp0_valid,
   output logic        resp1_valid,
   output logic        resp0_p,
   output logic        resp1_p,
   input  logic        resp0_ready,
   input  logic        resp1_ready,
   output logic [2:1]  pe_x,
   output logic [12:0] pe_weight,
   input  logic        pe_p,
   output logic        busy,
   output logic        grant_id
);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;
   state_t     state, next_state;
   logic [3:0] cnt;
   logic       last_grant, result, gnt, accept, resp_take;
   // on contention the requester that did not win last time goes first
   assign gnt       = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   assign accept    = (state == S_IDLE) & (req0_valid | req1_valid);
   assign resp_take = grant_id ? resp1_ready : resp0_ready;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end
   always_comb begin
      next_state = (state == S_IDLE)   ? (accept ? S_SETTLE : S_IDLE) :
                   (state == S_SETTLE) ? ((cnt == 4'd0) ? S_RESP : S_SETTLE) :
                   (state == S_RESP)   ? (resp_take ? S_IDLE : S_RESP) : S_IDLE;
   end
   always_comb begin
      busy        = state != S_IDLE;
      req0_ready  = accept & ~gnt;
      req1_ready  = accept & gnt;
      resp0_valid = (state == S_RESP) & ~grant_id;
      resp1_valid = (state == S_RESP) & grant_id;
      resp0_p     = result;
      resp1_p     = result;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pe_x       <= '0;
         pe_weight  <= '0;
         result     <= 1'b0;
         cnt        <= 4'd0;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
      end else if (accept) begin
         pe_x       <= gnt ? req1_x : req0_x;
         pe_weight  <= gnt ? req1_weight : req0_weight;
         grant_id   <= gnt;
         last_grant <= gnt;
         cnt        <= 4'(SETTLE - 1);
      end else if (state == S_SETTLE) begin
         if (cnt == 4'd0) result <= pe_p;
         else             cnt    <= cnt - 4'd1;
      end
   end
endmodule

// File: tb/tb_perceptron_arbiter.sv
// tb_perceptron_arbiter: scoreboard bench for perceptron_arbiter (SETTLE=1 and SETTLE=4 instances).
module tb_perceptron_arbiter;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        r0v = 0, r1v = 0, s0r = 1, s1r = 1;
   logic [2:1]  x0 = 0, x1 = 0;
   logic [12:0] w0 = 0, w1 = 0;
   logic        r0rdy, r1rdy, s0v, s1v, s0p, s1p, pe_p, busy, gid;
   logic [2:1]  pe_x;
   logic [12:0] pe_w;
   assign pe_p = pe_x[1] & pe_w[12];

   perceptron_arbiter #(.SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0v), .req1_valid(r1v), .req0_ready(r0rdy), .req1_ready(r1rdy),
      .req0_x(x0), .req1_x(x1), .req0_weight(w0), .req1_weight(w1),
      .resp0_valid(s0v), .resp1_valid(s1v), .resp0_p(s0p), .resp1_p(s1p),
      .resp0_ready(s0r), .resp1_ready(s1r),
      .pe_x(pe_x), .pe_weight(pe_w), .pe_p(pe_p), .busy(busy), .grant_id(gid));

   logic        b_r0v = 0, b_sp = 0;
   logic        b_r0rdy, b_r1rdy, b_s0v, b_s1v, b_s0p, b_s1p, b_busy, b_gid;
   logic [2:1]  b_pe_x;
   logic [12:0] b_pe_w;

   perceptron_arbiter #(.SETTLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(b_r0v), .req1_valid(1'b0), .req0_ready(b_r0rdy), .req1_ready(b_r1rdy),
      .req0_x(2'b01), .req1_x(2'b00), .req0_weight(13'h1ABC), .req1_weight(13'h0000),
      .resp0_valid(b_s0v), .resp1_valid(b_s1v), .resp0_p(b_s0p), .resp1_p(b_s1p),
      .resp0_ready(1'b1), .resp1_ready(1'b1),
      .pe_x(b_pe_x), .pe_weight(b_pe_w), .pe_p(b_sp), .busy(b_busy), .grant_id(b_gid));

   typedef struct {logic id; logic p;} exp_t;
   exp_t sb[$];
   int n_cmp = 0, n_bad = 0;

   function automatic logic model(input logic [2:1] x, input logic [12:0] w);
      return x[1] & w[12];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic id, input logic p);
      exp_t e;
      e.id = id;
      e.p  = p;
      sb.push_back(e);
   endtask

   // waits for a response on the SETTLE=1 instance, pops the scoreboard and compares
   task automatic get_resp(input string nm, input int lat, output logic p_out);
      exp_t e;
      int   n = 0;
      bit   got = 0;
      p_out = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         n_cmp++;
         if (r0rdy | r1rdy) begin
            n_bad++;
            $display("FAIL %s ready_while_busy: got %b%b want 00", nm, r1rdy, r0rdy);
         end
         if (s0v | s1v) begin
            got = 1;
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL %s sb_empty: got response with nothing expected", nm);
            end else begin
               e = sb.pop_front();
               n_cmp += 4;
               if ({s1v, s0v} !== (e.id ? 2'b10 : 2'b01)) begin
                  n_bad++;
                  $display("FAIL %s resp_id: got valid=%b%b want id %0d", nm, s1v, s0v, e.id);
               end
               p_out = e.id ? s1p : s0p;
               if (p_out !== e.p) begin
                  n_bad++;
                  $display("FAIL %s resp_p: got %b want %b", nm, p_out, e.p);
               end
               if (gid !== e.id) begin
                  n_bad++;
                  $display("FAIL %s grant_id: got %b want %b", nm, gid, e.id);
               end
               if (n != lat) begin
                  n_bad++;
                  $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
               end
            end
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: no response within 20 cycles", nm);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      step();
      step();
      @(negedge clk);
      n_cmp += 3;
      if ({busy, gid, s0v, s1v, b_busy} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset flags: got busy=%b gid=%b s0v=%b s1v=%b b_busy=%b want 0", busy, gid, s0v, s1v, b_busy);
      end
      if (pe_x !== 2'b00 || pe_w !== 13'h0) begin
         n_bad++;
         $display("FAIL reset pe: got x=%b w=%h want 0/0", pe_x, pe_w);
      end
      if (r0rdy | r1rdy) begin
         n_bad++;
         $display("FAIL reset ready: got %b%b want 00", r1rdy, r0rdy);
      end
      step();
      rst_n = 1;
   endtask

   task automatic test_single();
      logic p;
      r0v = 1; x0 = 2'b01; w0 = 13'h1FFF;
      @(negedge clk);
      n_cmp++;
      if (r0rdy !== 1'b1 || r1rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL single ready: got %b%b want 01", r1rdy, r0rdy);
      end
      push(0, model(x0, w0));
      step();
      r0v = 0;
      @(negedge clk);
      n_cmp++;
      if (pe_x !== 2'b01 || pe_w !== 13'h1FFF || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL single pe_drive: got x=%b w=%h busy=%b want 01/1fff/1", pe_x, pe_w, busy);
      end
      get_resp("single", 1, p);
      step();
   endtask

   task automatic test_contention_from_reset();
      logic p;
      rst_n = 0;
      step();
      rst_n = 1;
      r0v = 1; x0 = 2'b01; w0 = 13'h0000;
      r1v = 1; x1 = 2'b11; w1 = 13'h1C00;
      @(negedge clk);
      n_cmp++;
      if ({r1rdy, r0rdy} !== 2'b01) begin
         n_bad++;
         $display("FAIL contention first_grant: got %b%b want 01", r1rdy, r0rdy);
      end
      push(0, model(x0, w0));
      step();
      r0v = 0;
      get_resp("contention0", 2, p);
      step();
      @(negedge clk);
      n_cmp++;
      if ({r1rdy, r0rdy} !== 2'b10) begin
         n_bad++;
         $display("FAIL contention second_grant: got %b%b want 10", r1rdy, r0rdy);
      end
      push(1, model(x1, w1));
      step();
      r1v = 0;
      get_resp("contention1", 2, p);
      step();
   endtask

   task automatic test_back_to_back();
      logic p, g;
      r0v = 1; x0 = 2'b11; w0 = 13'h1000;
      r1v = 1; x1 = 2'b10; w1 = 13'h1FFF;
      for (int i = 0; i < 6; i++) begin
         g = 1'(i % 2);
         @(negedge clk);
         n_cmp++;
         if ({r1rdy, r0rdy} !== (g ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL b2b grant%0d: got %b%b want id %0d", i, r1rdy, r0rdy, g);
         end
         push(g, g ? model(x1, w1) : model(x0, w0));
         step();
         if (g) begin
            x1 = 2'($urandom_range(0, 3)); w1 = 13'($urandom);
         end else begin
            x0 = 2'($urandom_range(0, 3)); w0 = 13'($urandom);
         end
         get_resp("b2b", 2, p);
         step();
      end
      r0v = 0;
      r1v = 0;
   endtask

   task automatic test_backpressure();
      logic p;
      s0r = 0;
      r0v = 1; x0 = 2'b01; w0 = 13'h1234;
      @(negedge clk);
      n_cmp++;
      if (r0rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL bp accept: got %b want 1", r0rdy);
      end
      push(0, model(x0, w0));
      step();
      r0v = 0;
      r1v = 1; x1 = 2'b11; w1 = 13'h1001;
      get_resp("bp", 2, p);
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         n_cmp++;
         if (s0v !== 1'b1 || s0p !== p || r1rdy !== 1'b0 || s1v !== 1'b0) begin
            n_bad++;
            $display("FAIL bp hold%0d: got s0v=%b s0p=%b r1rdy=%b s1v=%b want 1/%b/0/0", i, s0v, s0p, r1rdy, s1v, p);
         end
      end
      step();
      s0r = 1;
      @(negedge clk);
      n_cmp++;
      if (s0v !== 1'b1) begin
         n_bad++;
         $display("FAIL bp release_cycle: got s0v=%b want 1", s0v);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || r1rdy !== 1'b1 || s0v !== 1'b0) begin
         n_bad++;
         $display("FAIL bp idle_after: got busy=%b r1rdy=%b s0v=%b want 0/1/0", busy, r1rdy, s0v);
      end
      push(1, model(x1, w1));
      step();
      r1v = 0;
      get_resp("bp_next", 2, p);
      step();
   endtask

   task automatic test_settle();
      exp_t e;
      logic vals [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      bit got = 0;
      b_r0v = 1;
      @(negedge clk);
      n_cmp++;
      if (b_r0rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL settle accept: got %b want 1", b_r0rdy);
      end
      step();
      b_r0v = 0;
      for (int k = 0; k < 4; k++) begin
         b_sp = vals[k];
         @(negedge clk);
         n_cmp++;
         if (b_s0v !== 1'b0 || b_busy !== 1'b1 || b_pe_x !== 2'b01 || b_pe_w !== 13'h1ABC) begin
            n_bad++;
            $display("FAIL settle cycle%0d: got valid=%b busy=%b x=%b w=%h want 0/1/01/1abc", k + 1, b_s0v, b_busy, b_pe_x, b_pe_w);
         end
         if (k == 3) push(0, vals[k]);
         step();
      end
      b_sp = ~vals[3];
      for (int n = 5; n < 12 && !got; n++) begin
         @(negedge clk);
         if (b_s0v | b_s1v) begin
            got = 1;
            e = sb.pop_front();
            n_cmp += 2;
            if (n != 5 || b_s1v !== 1'b0) begin
               n_bad++;
               $display("FAIL settle latency: got %0d s1v=%b want 5/0", n, b_s1v);
            end
            if (b_s0p !== e.p) begin
               n_bad++;
               $display("FAIL settle captured: got %b want %b", b_s0p, e.p);
            end
         end
         step();
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL settle timeout: no response");
      end
   endtask

   task automatic test_mid_reset();
      logic p;
      r0v = 1; x0 = 2'b11; w0 = 13'h1FFF;
      @(negedge clk);
      n_cmp++;
      if (r0rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst accept: got %b want 1", r0rdy);
      end
      step();
      r0v = 0;
      rst_n = 0;
      step();
      rst_n = 1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || pe_x !== 2'b00 || pe_w !== 13'h0 || s0v !== 1'b0 || s1v !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst state: got busy=%b x=%b w=%h s0v=%b s1v=%b want 0/00/0/0/0", busy, pe_x, pe_w, s0v, s1v);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         n_cmp++;
         if (s0v | s1v) begin
            n_bad++;
            $display("FAIL midrst phantom_resp: got %b%b want 00", s1v, s0v);
         end
      end
      step();
      r0v = 1; x0 = 2'b10; w0 = 13'h0F0F;
      r1v = 1; x1 = 2'b01; w1 = 13'h1000;
      @(negedge clk);
      n_cmp++;
      if ({r1rdy, r0rdy} !== 2'b01) begin
         n_bad++;
         $display("FAIL midrst grant: got %b%b want 01", r1rdy, r0rdy);
      end
      push(0, model(x0, w0));
      step();
      r0v = 0;
      r1v = 0;
      get_resp("midrst", 2, p);
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention_from_reset();
      test_back_to_back();
      test_backpressure();
      test_settle();
      test_mid_reset();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
